// File: rtl/fib_pkg.sv
// Shared constants for the Fibonacci peripheral register map and the
// Avalon-MM initiator state machine that drives it.
package fib_pkg;

   // Word addresses of the peripheral registers
   localparam logic [1:0] FIB_ADDR_LIMIT  = 2'd0;
   localparam logic [1:0] FIB_ADDR_CTRL   = 2'd1;
   localparam logic [1:0] FIB_ADDR_STATUS = 2'd2;
   localparam logic [1:0] FIB_ADDR_RESULT = 2'd3;

   // Register field values
   localparam logic [31:0] FIB_CTRL_START      = 32'h1;
   localparam int          FIB_STATUS_DONE_BIT = 0;

   // State encodings
   localparam logic [3:0] FIB_ST_IDLE      = 4'd0;
   localparam logic [3:0] FIB_ST_WR_LIMIT  = 4'd1;
   localparam logic [3:0] FIB_ST_WR_CLR    = 4'd2;
   localparam logic [3:0] FIB_ST_WR_START  = 4'd3;
   localparam logic [3:0] FIB_ST_GAP       = 4'd4;
   localparam logic [3:0] FIB_ST_POLL_RD   = 4'd5;
   localparam logic [3:0] FIB_ST_POLL_WAIT = 4'd6;
   localparam logic [3:0] FIB_ST_RES_RD    = 4'd7;
   localparam logic [3:0] FIB_ST_RES_WAIT  = 4'd8;
   localparam logic [3:0] FIB_ST_RESP      = 4'd9;

   typedef enum logic [3:0] {
      ST_IDLE      = FIB_ST_IDLE,
      ST_WR_LIMIT  = FIB_ST_WR_LIMIT,
      ST_WR_CLR    = FIB_ST_WR_CLR,
      ST_WR_START  = FIB_ST_WR_START,
      ST_GAP       = FIB_ST_GAP,
      ST_POLL_RD   = FIB_ST_POLL_RD,
      ST_POLL_WAIT = FIB_ST_POLL_WAIT,
      ST_RES_RD    = FIB_ST_RES_RD,
      ST_RES_WAIT  = FIB_ST_RES_WAIT,
      ST_RESP      = FIB_ST_RESP
   } fib_state_e;

endpackage

// File: rtl/fib_avalon_master.sv
// Avalon-MM initiator for the Fibonacci peripheral. Takes a limit on a
// valid/ready request port, programs the peripheral, starts it, polls the
// done bit with a programmable gap, reads the result and hands it back on a
// valid/ready response port. A bounded poll count turns a stuck peripheral
// into a timeout response instead of a hang.
module fib_avalon_master
   import fib_pkg::*;
#(
   parameter int POLL_LIMIT = 1024,
   parameter int POLL_GAP   = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   // request port
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_limit,
   // response port
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_timeout,
   // Avalon-MM initiator
   output logic [1:0]  av_address,
   output logic        av_chipselect,
   output logic        av_read,
   output logic        av_write,
   output logic [31:0] av_writedata,
   input  logic [31:0] av_readdata
);

   // Poll counter must be able to hold POLL_LIMIT itself; gap counter counts
   // 0..POLL_GAP and needs at least one bit even when POLL_GAP is 0.
   localparam int PW = $clog2(POLL_LIMIT + 1);
   localparam int GW = $clog2(POLL_GAP + 2);
   localparam logic [PW-1:0] POLL_MAX = PW'(POLL_LIMIT);
   localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP);

   fib_state_e    state_q, state_d;
   logic [31:0]   limit_q, limit_d;
   logic [PW-1:0] poll_q,  poll_d;
   logic [GW-1:0] gap_q,   gap_d;
   logic [31:0]   result_q, result_d;
   logic          timeout_q, timeout_d;

   logic          status_done;

   assign status_done = av_readdata[FIB_STATUS_DONE_BIT];

   // State and datapath registers; reset returns to IDLE with a cleared response
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         limit_q   <= '0;
         poll_q    <= '0;
         gap_q     <= '0;
         result_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         limit_q   <= limit_d;
         poll_q    <= poll_d;
         gap_q     <= gap_d;
         result_q  <= result_d;
         timeout_q <= timeout_d;
      end
   end

   // Next-state logic: job sequencing, poll/gap counting and response capture
   always_comb begin
      state_d   = state_q;
      limit_d   = limit_q;
      poll_d    = poll_q;
      gap_d     = gap_q;
      result_d  = result_q;
      timeout_d = timeout_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               limit_d = req_limit;
               poll_d  = '0;
               state_d = ST_WR_LIMIT;
            end
         end

         ST_WR_LIMIT: state_d = ST_WR_CLR;

         // Clearing status before the start write keeps a done bit left
         // over from the previous job from ending this one early.
         ST_WR_CLR:   state_d = ST_WR_START;

         ST_WR_START: begin
            gap_d   = '0;
            state_d = ST_GAP;
         end

         // POLL_GAP+1 idle cycles; the first one also hides the
         // peripheral's one-cycle start-flag transfer.
         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = ST_POLL_RD;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end

         ST_POLL_RD: begin
            if (poll_q != POLL_MAX) begin
               poll_d = poll_q + 1'b1;
            end
            state_d = ST_POLL_WAIT;
         end

         // Done takes priority over the limit check so that a done seen on
         // the very last permitted read still counts as success.
         ST_POLL_WAIT: begin
            if (status_done) begin
               state_d = ST_RES_RD;
            end else if (poll_q == POLL_MAX) begin
               result_d  = '0;
               timeout_d = 1'b1;
               state_d   = ST_RESP;
            end else begin
               gap_d   = '0;
               state_d = ST_GAP;
            end
         end

         ST_RES_RD: state_d = ST_RES_WAIT;

         ST_RES_WAIT: begin
            result_d  = av_readdata;
            timeout_d = 1'b0;
            state_d   = ST_RESP;
         end

         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // Bus strobes decoded straight from the state register so an
   // asynchronous reset removes any in-flight transaction immediately.
   always_comb begin
      av_address    = 2'd0;
      av_chipselect = 1'b0;
      av_read       = 1'b0;
      av_write      = 1'b0;
      av_writedata  = 32'd0;

      case (state_q)
         ST_WR_LIMIT: begin
            av_chipselect = 1'b1;
            av_write      = 1'b1;
            av_address    = FIB_ADDR_LIMIT;
            av_writedata  = limit_q;
         end
         ST_WR_CLR: begin
            av_chipselect = 1'b1;
            av_write      = 1'b1;
            av_address    = FIB_ADDR_STATUS;
            av_writedata  = 32'd0;
         end
         ST_WR_START: begin
            av_chipselect = 1'b1;
            av_write      = 1'b1;
            av_address    = FIB_ADDR_CTRL;
            av_writedata  = FIB_CTRL_START;
         end
         ST_POLL_RD: begin
            av_chipselect = 1'b1;
            av_read       = 1'b1;
            av_address    = FIB_ADDR_STATUS;
         end
         ST_RES_RD: begin
            av_chipselect = 1'b1;
            av_read       = 1'b1;
            av_address    = FIB_ADDR_RESULT;
         end
         default: begin
         end
      endcase
   end

   // Handshake flags and the held response
   assign req_ready   = (state_q == ST_IDLE);
   assign rsp_valid   = (state_q == ST_RESP);
   assign rsp_result  = result_q;
   assign rsp_timeout = timeout_q;

endmodule
